// File: rtl/error_log_writer_pkg.sv
// Shared types and constants for the error log writer.
package error_log_writer_pkg;

    // Record drain sequence: wait for a record, write low word, write high word, publish.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR_LO  = 2'd1,
        ST_WR_HI  = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    localparam int REC_W  = 64;
    localparam int WORD_W = 32;
    localparam int DROP_W = 16;

    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    // Saturating increment for the dropped-record counter.
    function automatic logic [DROP_W-1:0] drop_inc(input logic [DROP_W-1:0] cnt);
        return (cnt == DROP_MAX) ? cnt : cnt + DROP_W'(1);
    endfunction

endpackage

// File: rtl/error_log_writer.sv
// Drains 64-bit error records from the core error FIFO into a software ring
// buffer as two 32-bit writes (low word first, high word last so the record is
// only complete once its type/flags word lands), tracks the write index,
// counts records dropped while the ring is full and raises a level interrupt.
module error_log_writer
    import error_log_writer_pkg::*;
#(
    parameter int LOG2 = 6
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ena_i,
    input  logic [WORD_W-1:0]   base_i,
    input  logic [LOG2-1:0]     swrptr_i,
    input  logic                valid_i,
    input  logic [REC_W-1:0]    ecd_i,
    output logic                erd_o,
    output logic                mem_req_o,
    input  logic                mem_ack_i,
    output logic [WORD_W-1:0]   mem_addr_o,
    output logic [WORD_W-1:0]   mem_do_o,
    output logic [LOG2-1:0]     wptr_o,
    output logic [DROP_W-1:0]   dropcnt_o,
    output logic                intr_o,
    input  logic                intack_i
);

    state_e              state_q, state_d;
    logic [REC_W-1:0]    rec_q, rec_d;
    logic [LOG2-1:0]     wptr_q, wptr_d;
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic                intr_q, intr_d;

    logic [LOG2-1:0]     wptr_inc;
    logic                ring_full;
    logic [WORD_W-1:0]   slot_off;

    // One slot always stays empty, so full means the next index reaches software's read index.
    assign wptr_inc  = wptr_q + LOG2'(1);
    assign ring_full = (wptr_inc == swrptr_i);
    assign slot_off  = {{(WORD_W-LOG2-3){1'b0}}, wptr_q, 3'b000};

    assign erd_o     = (state_q == ST_IDLE) & ena_i & valid_i;
    assign wptr_o    = wptr_q;
    assign dropcnt_o = drop_q;
    assign intr_o    = intr_q;

    // Memory write decode: address and data follow state, so they hold while waiting for ack.
    always_comb begin
        mem_req_o  = 1'b0;
        mem_addr_o = '0;
        mem_do_o   = '0;
        case (state_q)
            ST_WR_LO: begin
                mem_req_o  = 1'b1;
                mem_addr_o = base_i + slot_off;
                mem_do_o   = rec_q[WORD_W-1:0];
            end
            ST_WR_HI: begin
                mem_req_o  = 1'b1;
                mem_addr_o = base_i + (slot_off | 32'h4);
                mem_do_o   = rec_q[REC_W-1:WORD_W];
            end
            default: ;
        endcase
    end

    // Next-state logic for the drain sequence, index, drop counter and interrupt.
    always_comb begin
        state_d = state_q;
        rec_d   = rec_q;
        wptr_d  = wptr_q;
        drop_d  = drop_q;
        intr_d  = intr_q;

        if (intack_i) begin
            intr_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (erd_o) begin
                    if (ring_full) begin
                        drop_d = drop_inc(drop_q);
                    end else begin
                        rec_d   = ecd_i;
                        state_d = ST_WR_LO;
                    end
                end
            end
            ST_WR_LO: begin
                if (mem_ack_i) begin
                    state_d = ST_WR_HI;
                end
            end
            ST_WR_HI: begin
                if (mem_ack_i) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                wptr_d  = wptr_inc;
                intr_d  = 1'b1;   // a new commit outranks a simultaneous acknowledge
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and data registers; reset abandons any partial record.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            rec_q   <= '0;
            wptr_q  <= '0;
            drop_q  <= '0;
            intr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rec_q   <= rec_d;
            wptr_q  <= wptr_d;
            drop_q  <= drop_d;
            intr_q  <= intr_d;
        end
    end

endmodule

// File: doc/error_log_writer.md
# error_log_writer

Downstream consumer of the core error FIFO. Pops 64-bit error records via the FIFO's VALID/ERD handshake and writes each record as two 32-bit words into a software-visible ring buffer in memory. Maintains the ring write index, a saturating count of dropped records when the ring is full, and a level interrupt toward the interrupt controller.

## Interface
- LOG2, 6, log2 of ring entries; ring holds 2^LOG2 records of 8 bytes each
- CLK  in  1  clock, all state on posedge
- RESET  in  1  asynchronous, active-low reset
- ENA  in  1  drain enable; when low no new record is popped
- BASE  in  32  ring byte base address, 8-byte aligned; sampled per write
- SWRPTR  in  LOG2  software read index (next record software will consume)
- VALID  in  1  FIFO has a record on ECD
- ECD  in  64  FIFO record
- ERD  out  1  pop strobe to FIFO; record consumed at posedge where VALID&ERD
- MemREQ  out  1  memory write request
- MemACK  in  1  write accepted; sampled only at posedges where MemREQ=1
- MemADDR  out  32  write byte address
- MemDO  out  32  write data
- WPTR  out  LOG2  ring write index (next slot to fill)
- DROPCNT  out  16  records discarded because ring full, saturates at 16'hFFFF
- INTR  out  1  level interrupt: one or more records committed since last INTACK
- INTACK  in  1  single-cycle clear of INTR

## Operation
- States: IDLE, WR_LO, WR_HI, COMMIT.
- Full is defined as (WPTR+1) mod 2^LOG2 == SWRPTR; one slot always stays empty. Empty is WPTR==SWRPTR, which is software's concern only.
- ERD = (state==IDLE) & ENA & VALID, combinational.
- IDLE with ERD=1 and not full: latch ECD into RecReg, go to WR_LO.
- IDLE with ERD=1 and full: record discarded, DROPCNT += 1 unless already FFFF, stay in IDLE.
- WR_LO: MemREQ=1, MemADDR=BASE+{WPTR,3'b000}, MemDO=RecReg[31:0]. On MemACK go to WR_HI.
- WR_HI: MemREQ=1, MemADDR=BASE+{WPTR,3'b100}, MemDO=RecReg[63:32]. On MemACK go to COMMIT.
- The high word carries the record type/flags and is written last, so a record is complete once its high word lands.
- COMMIT: WPTR <= WPTR+1, wrapping modulo 2^LOG2; INTR <= 1; go to IDLE.
- Address add is 32-bit, modulo 2^32; the index is zero-extended.
- INTR: set in COMMIT, cleared by INTACK. If both occur in the same cycle, set wins.
- ENA falling mid-record: the current record completes through COMMIT; no further pops.
- SWRPTR changing mid-record has no effect on the record in flight; full is evaluated only in IDLE.
- MemADDR and MemDO stay stable while MemREQ=1 and MemACK=0.

## Timing
- Reset values: state IDLE, MemREQ 0, MemADDR 0, MemDO 0, WPTR 0, DROPCNT 0, INTR 0, RecReg 0.
- ERD is 0 during reset because VALID is 0.
- Pop edge t. MemREQ is high from t+1. With MemACK tied high, the high word is written at t+2 and WPTR/INTR update at t+3. Minimum 4 cycles per record; the next pop can occur at t+4.
- Each MemACK wait cycle adds one cycle per word.
- Drop path: one record per cycle while full, ENA and VALID hold.
- Reset asserted mid-write: MemREQ drops asynchronously, the partial record is abandoned, and WPTR returns to 0. Software must re-sync after reset.

## Structure
- Shared package: state enum (IDLE, WR_LO, WR_HI, COMMIT), record width constant 64, DROPCNT width 16.
- No sub-module: one always_ff for state/registers plus a combinational decode for ERD, MemREQ, MemADDR and MemDO.

## Test plan
- Single record: ECD=64'h0123_4567_89AB_CDEF, BASE=32'h0000_1000, WPTR=0, MemACK=1. Expect writes 0x1000←89ABCDEF then 0x1004←01234567, WPTR=1, INTR=1, one ERD pulse.
- MemACK delayed 3 cycles on each word. Expect MemADDR/MemDO held stable, exactly two writes, no extra ERD.
- Ring full (LOG2=2, WPTR=3, SWRPTR=0), 5 records queued. Expect 5 ERD pulses, DROPCNT=5, no MemREQ. Then set SWRPTR=1: next record written at BASE+0x18 and WPTR wraps to 0.
- DROPCNT preset near saturation via 65540 drops. Expect DROPCNT=FFFF and no wrap.
- INTACK in the same cycle as COMMIT leaves INTR=1. INTACK alone afterwards clears INTR=0.
- Reset asserted while in WR_HI with MemREQ=1. Expect MemREQ=0 immediately, WPTR=0, INTR=0, and normal operation after release.
